sauria_dma_request_issuer: RTL and testbench
============================================

SAURIA_DMA_REQUEST_ISSUER -- requirements
Module: sauria_dma_request_issuer

Interface
REQ-001 Parameter ADDR_W, 32: width of base addresses, pointer counters and request address.
REQ-002 Parameter MAX_OUT, 4: maximum outstanding DMA requests; outstanding counter is clog2(MAX_OUT+1) bits.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rstn  in  1  synchronous, active-low reset.
REQ-005 Port start  in  1  pulse; begins a tile sequence from IDLE.
REQ-006 Port ifmaps_base, weights_base, psums_base  in  ADDR_W each  tensor base addresses; stable while busy.
REQ-007 Port ifmap_xcounter, ifmap_ycounter, ifmap_ccounter  in  ADDR_W each  upstream ifmap pointer offsets.
REQ-008 Port psums_xcounter, psums_ycounter, psums_kcounter  in  ADDR_W each  upstream psums pointer offsets.
REQ-009 Port weights_ccounter, weights_kcounter  in  ADDR_W each  upstream weights pointer offsets.
REQ-010 Port ifmaps_change, psums_change, weights_change, last_iter  in  1 each  upstream tile-change flags and last-iteration flag.
REQ-011 Port ptr_advance  out  1  one-cycle pulse to the upstream advance input.
REQ-012 Port req_valid  out  1, req_ready  in  1, req_addr  out  ADDR_W, req_kind  out  2 (0 ifmaps rd, 1 weights rd, 2 psums rd, 3 psums wr)  DMA request channel.
REQ-013 Port dma_done  in  1  one-cycle pulse per completed request.
REQ-014 Port busy  out  1, finished  out  1 (one-cycle pulse), protocol_err  out  1 (sticky).

Function
REQ-015 States SHALL be IDLE, CHECK, ISSUE, DRAIN, ADVANCE, FINAL_WB, DONE.
REQ-016 IDLE: start moves to CHECK; start in any other state is ignored; busy=1 in every state except IDLE.
REQ-017 CHECK (one cycle): latch the change flags and last_iter; compute addresses modulo 2^ADDR_W: ifmaps = ifmaps_base+x+y+c, weights = weights_base+c+k, psums = psums_base+x+y+k.
REQ-018 ISSUE: emit requests in fixed order and skip kinds whose condition is false: psums wr (psums_change and not first tile, address = previous psums address), ifmaps rd (ifmaps_change), weights rd (weights_change), psums rd (psums_change).
REQ-019 req_valid, req_addr and req_kind SHALL hold stable until the cycle req_valid&&req_ready; the next request may be presented the following cycle.
REQ-020 The outstanding counter SHALL increment on handshake and decrement on dma_done; both in one cycle leave it unchanged; while it equals MAX_OUT, req_valid SHALL be 0.
REQ-021 If no request is needed, ISSUE SHALL exit in one cycle; after the last request it SHALL go to DRAIN.
REQ-022 DRAIN: when outstanding==0, go to FINAL_WB if latched last_iter, else go to ADVANCE.
REQ-023 ADVANCE: ptr_advance=1 for exactly one cycle; save the current psums address as the previous address; clear the first-tile flag; then go to CHECK, which samples the counters after they have updated.
REQ-024 FINAL_WB: issue a psums wr at the current psums address, wait for outstanding==0, then go to DONE.
REQ-025 DONE: finished=1 for one cycle; set the first-tile flag; return to IDLE.
REQ-026 A dma_done while outstanding==0 SHALL be ignored for counting and SHALL set protocol_err.

Reset
REQ-027 When rstn=0 at a clock edge: state IDLE; outstanding 0; first-tile flag 1; previous address 0; req_valid, ptr_advance, finished, busy and protocol_err 0; req_addr 0; req_kind 0.
REQ-028 Reset mid-transfer SHALL drop req_valid on the next edge; later dma_done pulses SHALL be treated as at IDLE with outstanding 0, so they set protocol_err.

Configuration
REQ-029 Macro SAURIA_DMA_PSUMS_WB_EN.
REQ-030 With the macro defined, psums wr requests are issued per REQ-018 and REQ-024.
REQ-031 Without the macro, no kind-3 request is ever issued; FINAL_WB is bypassed and DRAIN with last_iter goes directly to DONE.

Verification
REQ-032 Reset then start, all flags 1, last_iter 1, bases 0x1000/0x2000/0x3000, counters 0, req_ready 1 -> requests 0x1000 k0, 0x2000 k1, 0x3000 k2; after 3 dma_done, wr 0x3000 k3, then finished pulse.
REQ-033 Only weights_change=1, ccounter=0x40, weights_base 0x2000 -> single request 0x2040 k1, then ptr_advance pulse once outstanding reaches 0.
REQ-034 req_ready held 0 for 5 cycles -> req_valid, req_addr and req_kind stable for all 5 cycles; exactly one handshake.
REQ-035 MAX_OUT=1, dma_done delayed 3 cycles -> second req_valid rises only after dma_done; a dma_done coinciding with a handshake leaves outstanding at 1.
REQ-036 rstn low during ISSUE with 2 requests outstanding -> req_valid 0 next cycle; the 2 later dma_done pulses set protocol_err; state IDLE.

Source files
------------

// File: rtl/sauria_dma_request_issuer.sv
// sauria_dma_request_issuer: walks tile pointers and issues DMA requests for each tile.
// Define SAURIA_DMA_PSUMS_WB_EN to enable psums write-back requests (kind 3) and FINAL_WB.
module sauria_dma_request_issuer #(
    parameter int ADDR_W = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] ifmaps_base,
    input  logic [ADDR_W-1:0] weights_base,
    input  logic [ADDR_W-1:0] psums_base,
    input  logic [ADDR_W-1:0] ifmap_xcounter,
    input  logic [ADDR_W-1:0] ifmap_ycounter,
    input  logic [ADDR_W-1:0] ifmap_ccounter,
    input  logic [ADDR_W-1:0] psums_xcounter,
    input  logic [ADDR_W-1:0] psums_ycounter,
    input  logic [ADDR_W-1:0] psums_kcounter,
    input  logic [ADDR_W-1:0] weights_ccounter,
    input  logic [ADDR_W-1:0] weights_kcounter,
    input  logic              ifmaps_change,
    input  logic              psums_change,
    input  logic              weights_change,
    input  logic              last_iter,
    output logic              ptr_advance,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [1:0]        req_kind,
    input  logic              dma_done,
    output logic              busy,
    output logic              finished,
    output logic              protocol_err
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUT);
`ifdef SAURIA_DMA_PSUMS_WB_EN
    localparam logic WB_EN = 1'b1;
`else
    localparam logic WB_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, ADVANCE, FINAL_WB, DONE} state_t;
    state_t state_q, state_d;
    logic [OW-1:0] out_q, out_d;
    logic [3:0] pend_q, pend_d;
    logic last_q, last_d, first_q, first_d, perr_q, perr_d, valid_q, valid_d;
    logic adv_q, adv_d, fin_q, fin_d, busy_q, busy_d;
    logic [ADDR_W-1:0] ifm_q, ifm_d, wts_q, wts_d, psum_q, psum_d, prev_q, prev_d, addr_q, addr_d;
    logic [1:0] kind_q, kind_d;
    logic hs, dn, issuing;
    assign ptr_advance = adv_q;
    assign req_valid = valid_q;
    assign req_addr = addr_q;
    assign req_kind = kind_q;
    assign busy = busy_q;
    assign finished = fin_q;
    assign protocol_err = perr_q;
    // pend bits in issue order: [0] psums wr, [1] ifmaps rd, [2] weights rd, [3] psums rd
    always_comb begin
        hs = valid_q & req_ready;
        dn = dma_done & (out_q != '0);
        out_d = out_q + OW'(hs) - OW'(dn);
        perr_d = perr_q | (dma_done & (out_q == '0));
        pend_d = hs ? pend_q & (pend_q - 4'd1) : pend_q;
        state_d = state_q;
        last_d = last_q;
        first_d = first_q;
        prev_d = prev_q;
        ifm_d = ifm_q;
        wts_d = wts_q;
        psum_d = psum_q;
        issuing = (state_q == ISSUE || state_q == FINAL_WB) && !valid_q && pend_q != '0 && out_d < MAX_CNT;
        valid_d = issuing | (valid_q & ~req_ready);
        kind_d = !issuing ? kind_q : pend_q[0] ? 2'd3 : pend_q[1] ? 2'd0 : pend_q[2] ? 2'd1 : 2'd2;
        addr_d = !issuing ? addr_q :
                 pend_q[0] ? (state_q == FINAL_WB ? psum_q : prev_q) :
                 pend_q[1] ? ifm_q : pend_q[2] ? wts_q : psum_q;
        case (state_q)
            IDLE: state_d = start ? CHECK : IDLE;
            CHECK: begin
                last_d = last_iter;
                ifm_d = ifmaps_base + ifmap_xcounter + ifmap_ycounter + ifmap_ccounter;
                wts_d = weights_base + weights_ccounter + weights_kcounter;
                psum_d = psums_base + psums_xcounter + psums_ycounter + psums_kcounter;
                pend_d = {psums_change, weights_change, ifmaps_change, WB_EN & psums_change & ~first_q};
                state_d = ISSUE;
            end
            ISSUE: state_d = (pend_d == '0 && !valid_d) ? DRAIN : ISSUE;
            DRAIN: begin
                state_d = out_q != '0 ? DRAIN : !last_q ? ADVANCE : WB_EN ? FINAL_WB : DONE;
                pend_d = (out_q == '0 && last_q && WB_EN) ? 4'b0001 : pend_d;
            end
            ADVANCE: begin
                prev_d = psum_q;
                first_d = 1'b0;
                state_d = CHECK;
            end
            FINAL_WB: state_d = (pend_d == '0 && !valid_d && out_d == '0) ? DONE : FINAL_WB;
            DONE: begin
                first_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        adv_d = state_d == ADVANCE;
        fin_d = state_d == DONE;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            out_q <= '0;
            pend_q <= '0;
            last_q <= 1'b0;
            first_q <= 1'b1;
            perr_q <= 1'b0;
            valid_q <= 1'b0;
            adv_q <= 1'b0;
            fin_q <= 1'b0;
            busy_q <= 1'b0;
            ifm_q <= '0;
            wts_q <= '0;
            psum_q <= '0;
            prev_q <= '0;
            addr_q <= '0;
            kind_q <= '0;
        end else begin
            state_q <= state_d;
            out_q <= out_d;
            pend_q <= pend_d;
            last_q <= last_d;
            first_q <= first_d;
            perr_q <= perr_d;
            valid_q <= valid_d;
            adv_q <= adv_d;
            fin_q <= fin_d;
            busy_q <= busy_d;
            ifm_q <= ifm_d;
            wts_q <= wts_d;
            psum_q <= psum_d;
            prev_q <= prev_d;
            addr_q <= addr_d;
            kind_q <= kind_d;
        end
    end
endmodule

// File: tb/tb_sauria_dma_request_issuer.sv
// tb_sauria_dma_request_issuer: directed checks of the DMA request issuer (default and MAX_OUT=1 instances).
// Expectations for psums write-back follow SAURIA_DMA_PSUMS_WB_EN when it is defined.
module tb_sauria_dma_request_issuer;
    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, start1 = 1'b0;
    logic [31:0] ib = 32'h1000, wb = 32'h2000, pb = 32'h3000;
    logic [31:0] ix, iy, ic, px, py, pk, wc, wk;
    logic ich, pch, wch, last;
    logic rdy = 1'b1, done = 1'b0, rdy1 = 1'b1, done1 = 1'b0;
    logic adv, valid, busy, fin, perr, adv1, v1, busy1, fin1, perr1;
    logic [31:0] addr, a1;
    logic [1:0] kind, k1;
    int checks = 0, errs = 0, hs_cnt = 0, hs0;
    always #5 clk = ~clk;
    always @(posedge clk) if (valid && rdy) hs_cnt++;
    sauria_dma_request_issuer u_dut (
        .clk(clk), .rstn(rstn), .start(start),
        .ifmaps_base(ib), .weights_base(wb), .psums_base(pb),
        .ifmap_xcounter(ix), .ifmap_ycounter(iy), .ifmap_ccounter(ic),
        .psums_xcounter(px), .psums_ycounter(py), .psums_kcounter(pk),
        .weights_ccounter(wc), .weights_kcounter(wk),
        .ifmaps_change(ich), .psums_change(pch), .weights_change(wch), .last_iter(last),
        .ptr_advance(adv), .req_valid(valid), .req_ready(rdy), .req_addr(addr), .req_kind(kind),
        .dma_done(done), .busy(busy), .finished(fin), .protocol_err(perr)
    );
    sauria_dma_request_issuer #(.ADDR_W(32), .MAX_OUT(1)) u_one (
        .clk(clk), .rstn(rstn), .start(start1),
        .ifmaps_base(ib), .weights_base(wb), .psums_base(pb),
        .ifmap_xcounter(ix), .ifmap_ycounter(iy), .ifmap_ccounter(ic),
        .psums_xcounter(px), .psums_ycounter(py), .psums_kcounter(pk),
        .weights_ccounter(wc), .weights_kcounter(wk),
        .ifmaps_change(ich), .psums_change(pch), .weights_change(wch), .last_iter(last),
        .ptr_advance(adv1), .req_valid(v1), .req_ready(rdy1), .req_addr(a1), .req_kind(k1),
        .dma_done(done1), .busy(busy1), .finished(fin1), .protocol_err(perr1)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic cfg(input logic i, input logic w, input logic p, input logic l);
        {ix, iy, ic, px, py, pk, wc, wk} = '0;
        {ich, wch, pch, last} = {i, w, p, l};
    endtask
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask
    task automatic wait_req(input string tag, input logic [31:0] a, input logic [1:0] k, input logic with_done);
        int n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(valid), 1);
        chk({tag, "_addr"}, addr, a);
        chk({tag, "_kind"}, 32'(kind), 32'(k));
        done = with_done;
        tick();
        done = 1'b0;
    endtask
    function automatic logic sig(input int s);
        return s == 0 ? fin : adv;
    endfunction
    task automatic wait_for(input string tag, input int s);
        int n = 0;
        while (!sig(s) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(sig(s)), 1);
    endtask
    initial begin
        cfg(1, 1, 1, 1);
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_addr", addr, 0);
        chk("rst_kind", 32'(kind), 0);
        chk("rst_misc", 32'({adv, fin, perr}), 0);
        rstn = 1'b1;
        tick();
        // all three reads on the first tile, then final write-back
        go();
        chk("t1_busy", 32'(busy), 1);
        wait_req("t1_ifm", 32'h1000, 0, 0);
        wait_req("t1_wts", 32'h2000, 1, 0);
        wait_req("t1_psr", 32'h3000, 2, 0);
        tick();
        chk("t1_wait", 32'({fin, busy}), 1);
        pulse_done();
        pulse_done();
        pulse_done();
`ifdef SAURIA_DMA_PSUMS_WB_EN
        wait_req("t1_wr", 32'h3000, 3, 0);
        pulse_done();
`endif
        wait_for("t1_fin", 0);
        tick();
        chk("t1_fin_pulse", 32'({fin, busy}), 0);
        // weights-only tile, then ptr_advance and a psums-only last tile
        cfg(0, 1, 0, 0);
        wb = 32'h2000;
        wc = 32'h40;
        go();
        wait_req("t2_wts", 32'h2040, 1, 0);
        {wch, pch, last, px} = {1'b0, 1'b1, 1'b1, 32'h10};
        chk("t2_noadv", 32'(adv), 0);
        tick();
        chk("t2_noadv2", 32'(adv), 0);
        pulse_done();
        wait_for("t2_adv", 1);
        tick();
        chk("t2_adv_pulse", 32'(adv), 0);
`ifdef SAURIA_DMA_PSUMS_WB_EN
        wait_req("t2_wrprev", 32'h3000, 3, 0);
`endif
        wait_req("t2_psr", 32'h3010, 2, 0);
        pulse_done();
`ifdef SAURIA_DMA_PSUMS_WB_EN
        pulse_done();
        wait_req("t2_wrfin", 32'h3010, 3, 0);
        pulse_done();
`endif
        wait_for("t2_fin", 0);
        tick();
        // back-pressure: request must hold for 5 stalled cycles
        cfg(1, 0, 0, 1);
        {ix, iy, ic} = {32'd1, 32'd2, 32'd3};
        rdy = 1'b0;
        go();
        for (int n = 0; n < 40 && !valid; n++) tick();
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(valid), 1);
            chk("t3_hold_addr", addr, 32'h1006);
            chk("t3_hold_kind", 32'(kind), 0);
            tick();
        end
        rdy = 1'b1;
        tick();
        tick();
        tick();
        chk("t3_one_hs", 32'(hs_cnt - hs0), 1);
        chk("t3_no_more", 32'(valid), 0);
        pulse_done();
`ifdef SAURIA_DMA_PSUMS_WB_EN
        wait_req("t3_wr", 32'h3000, 3, 0);
        pulse_done();
`endif
        wait_for("t3_fin", 0);
        tick();
        // dma_done on the same cycle as a handshake keeps outstanding at 1
        cfg(1, 1, 0, 1);
        go();
        wait_req("t5_ifm", 32'h1000, 0, 0);
        wait_req("t5_wts", 32'h2000, 1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_still_busy", 32'({fin, busy}), 1);
            tick();
        end
        pulse_done();
`ifdef SAURIA_DMA_PSUMS_WB_EN
        wait_req("t5_wr", 32'h3000, 3, 0);
        pulse_done();
`endif
        wait_for("t5_fin", 0);
        chk("t5_perr", 32'(perr), 0);
        tick();
        // MAX_OUT=1: second request waits for dma_done
        cfg(1, 1, 0, 1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int n = 0; n < 40 && !v1; n++) tick();
        chk("t4_first", {a1[29:0], k1}, {30'h1000, 2'd0});
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t4_blocked", 32'(v1), 0);
            tick();
        end
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        chk("t4_second", 32'(v1), 1);
        chk("t4_second_addr", {a1[29:0], k1}, {30'h2000, 2'd1});
        tick();
        tick();
        chk("t4_blocked2", 32'(v1), 0);
        chk("t4_perr", 32'(perr1), 0);
        // reset during ISSUE with two requests outstanding
        cfg(1, 1, 1, 1);
        go();
        wait_req("t6_ifm", 32'h1000, 0, 0);
        wait_req("t6_wts", 32'h2000, 1, 0);
        for (int n = 0; n < 40 && !valid; n++) tick();
        chk("t6_third", 32'(valid), 1);
        rdy = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        rdy = 1'b1;
        chk("t6_rst_valid", 32'(valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_perr0", 32'(perr), 0);
        pulse_done();
        chk("t6_perr1", 32'(perr), 1);
        pulse_done();
        chk("t6_perr_sticky", 32'(perr), 1);
        chk("t6_idle", 32'({busy, valid}), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
